ddr_write_queue: RTL and testbench

Sits directly downstream of the AXI write front end. It captures the per-beat memory write stream (`addr`, `wdata`, `wstrobe`, `wburst`) into a first-word-fall-through (FWFT) FIFO and converts each beat's size and offset into a byte mask. It drains entries to the DDR command scheduler over a valid/ready handshake. It returns `wfull` and `werr` to the front end's write FSM for flow control and error reporting.

---
 rtl/ddr_ctrl_pkg.sv | 13 +
 rtl/byte_mask_gen.sv | 37 +++
 rtl/ddr_write_queue.sv | 118 +++++++++++
 tb/tb_ddr_write_queue.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_ctrl_pkg.sv
// Shared types and constants for the DDR controller write/read queue paths.
package ddr_ctrl_pkg;

    localparam int BEAT_MAX_SIZE = 3;
    localparam int LANES         = 8;

    typedef struct packed {
        logic [7:0]  addr;
        logic [63:0] data;
        logic [7:0]  mask;
    } wq_entry_t;

endpackage

// File: rtl/byte_mask_gen.sv
// Converts a beat size and the low address bits into an 8-lane byte-enable mask
// and flags beats that are not naturally aligned or exceed the maximum size.
module byte_mask_gen
    import ddr_ctrl_pkg::*;
(
    input  logic [2:0]       addr,
    input  logic [2:0]       wburst,
    output logic [LANES-1:0] mask,
    output logic             misaligned
);

    always_comb begin
        mask       = '0;
        misaligned = 1'b0;
        case (wburst)
            3'd0: mask = 8'h01 << addr;
            3'd1: begin
                mask       = 8'h03 << addr;
                misaligned = addr[0];
            end
            3'd2: begin
                mask       = 8'h0F << addr;
                misaligned = |addr[1:0];
            end
            3'd3: begin
                mask       = 8'hFF << addr;
                misaligned = |addr;
            end
            default: mask = '0;
        endcase
        // Sizes above the largest beat are rejected the same way as misalignment.
        if (int'(wburst) > BEAT_MAX_SIZE) begin
            misaligned = 1'b1;
        end
    end

endmodule

// File: rtl/ddr_write_queue.sv
// FWFT write-beat queue between the AXI write front end and the DDR command
// scheduler; builds byte masks on entry and drains over valid/ready.
module ddr_write_queue
    import ddr_ctrl_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int FULL_MARGIN = 2,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     wstrobe,
    input  logic [2:0]               wburst,
    input  logic                     flush,
    output logic                     wfull,
    output logic                     werr,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [ADDR_W-1:0]        cmd_addr,
    output logic [DATA_W-1:0]        cmd_data,
    output logic [7:0]               cmd_mask,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] WFULL_THR = LVL_W'(DEPTH - FULL_MARGIN);

    wq_entry_t        mem [DEPTH];
    wq_entry_t        push_entry;
    wq_entry_t        head;

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic [LVL_W-1:0] level_next;
    logic             wfull_reg;
    logic             werr_reg;

    logic [7:0]       beat_mask;
    logic             misaligned;
    logic             full;
    logic             push;
    logic             pop;

    byte_mask_gen u_mask (
        .addr       (addr[2:0]),
        .wburst     (wburst),
        .mask       (beat_mask),
        .misaligned (misaligned)
    );

    // Full is judged on the pre-pop level, so a pop never makes room for a same-cycle push.
    assign full      = (level_reg == DEPTH_LVL);
    assign cmd_valid = (level_reg != '0);
    assign push      = wstrobe && !misaligned && !full && !flush;
    assign pop       = cmd_valid && cmd_ready && !flush;

    always_comb begin
        push_entry.addr = 8'(addr);
        push_entry.data = 64'(wdata);
        push_entry.mask = beat_mask;
    end

    always_comb begin
        level_next = level_reg;
        if (flush) begin
            level_next = '0;
        end else begin
            case ({push, pop})
                2'b10:   level_next = level_reg + 1'b1;
                2'b01:   level_next = level_reg - 1'b1;
                default: level_next = level_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            wfull_reg  <= 1'b0;
            werr_reg   <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            level_reg <= level_next;
            wfull_reg <= (level_next >= WFULL_THR);
            werr_reg  <= wstrobe && !flush && (misaligned || full);
        end
    end

    // Entry storage carries no reset; contents are only observed while cmd_valid is high.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_entry;
        end
    end

    assign head     = mem[rd_ptr_reg];
    assign cmd_addr = ADDR_W'({head.addr[7:3], 3'b000});
    assign cmd_data = DATA_W'(head.data);
    assign cmd_mask = head.mask;
    assign level    = level_reg;
    assign wfull    = wfull_reg;
    assign werr     = werr_reg;

endmodule

// File: tb/tb_ddr_write_queue.sv
// Scoreboard bench for ddr_write_queue: stimulus queues expected beats, a
// negedge monitor compares every accepted head entry in order.
module tb_ddr_write_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  addr = '0;
    logic [63:0] wdata = '0;
    logic        wstrobe = 1'b0;
    logic [2:0]  wburst = '0;
    logic        flush = 1'b0;
    logic        wfull;
    logic        werr;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [7:0]  cmd_addr;
    logic [63:0] cmd_data;
    logic [7:0]  cmd_mask;
    logic [3:0]  level;

    typedef struct {
        logic [7:0]  a;
        logic [63:0] d;
        logic [7:0]  m;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   pops = 0;
    int   exp_total = 0;

    ddr_write_queue #(
        .DEPTH       (8),
        .FULL_MARGIN (2),
        .ADDR_W      (8),
        .DATA_W      (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .wdata     (wdata),
        .wstrobe   (wstrobe),
        .wburst    (wburst),
        .flush     (flush),
        .wfull     (wfull),
        .werr      (werr),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .cmd_mask  (cmd_mask),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a handshake seen at the negedge completes at the next posedge.
    always @(negedge clk) begin
        if (!rst && cmd_valid && cmd_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got addr 0x%0h data 0x%0h, expected no entry", cmd_addr, cmd_data);
            end else begin
                mon_e = exp_q.pop_front();
                $display("beat addr=0x%02h data=0x%016h mask=0x%02h", cmd_addr, cmd_data, cmd_mask);
                check("cmd_addr", 64'(cmd_addr), 64'(mon_e.a));
                check("cmd_data", cmd_data, mon_e.d);
                check("cmd_mask", 64'(cmd_mask), 64'(mon_e.m));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [63:0] d, input logic [2:0] sz,
                        input bit accept, input logic [7:0] exp_a, input logic [7:0] exp_m);
        addr    = a;
        wdata   = d;
        wburst  = sz;
        wstrobe = 1'b1;
        if (accept) begin
            exp_q.push_back('{exp_a, d, exp_m});
            exp_total++;
        end
        tick();
        wstrobe = 1'b0;
    endtask

    task automatic discard_expected();
        exp_total -= exp_q.size();
        exp_q.delete();
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        cmd_ready = 1'b1;
        while (level != 4'd0 && n < max_cycles) begin
            tick();
            n++;
        end
        check("drain_level", 64'(level), 64'd0);
        cmd_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset state, single full-width beat
        #2;
        check("rst_level", 64'(level), 64'd0);
        check("rst_valid", 64'(cmd_valid), 64'd0);
        check("rst_wfull", 64'(wfull), 64'd0);
        check("rst_werr", 64'(werr), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        push(8'h10, 64'h1122334455667788, 3'd3, 1'b1, 8'h10, 8'hFF);
        check("t1_valid", 64'(cmd_valid), 64'd1);
        check("t1_level", 64'(level), 64'd1);
        check("t1_addr", 64'(cmd_addr), 64'h10);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check("t1_valid_after_pop", 64'(cmd_valid), 64'd0);
        check("t1_level_after_pop", 64'(level), 64'd0);

        // 2: sub-word masks and illegal beats
        push(8'h06, 64'h0000_0000_AAAA_0000, 3'd1, 1'b1, 8'h00, 8'hC0);
        push(8'h03, 64'h0000_0000_BB00_0000, 3'd0, 1'b1, 8'h00, 8'h08);
        check("t2_level", 64'(level), 64'd2);
        push(8'h06, 64'hDEAD, 3'd2, 1'b0, 8'h00, 8'h00);
        check("t2_werr_misaligned", 64'(werr), 64'd1);
        check("t2_level_unchanged", 64'(level), 64'd2);
        push(8'h00, 64'hBEEF, 3'd4, 1'b0, 8'h00, 8'h00);
        check("t2_werr_oversize", 64'(werr), 64'd1);
        tick();
        check("t2_werr_clear", 64'(werr), 64'd0);
        drain(10);

        // 3: fill, wfull threshold, overflow with simultaneous pop, ordered drain
        for (int i = 0; i < 8; i++) begin
            push(8'(i * 8), 64'hD0 + 64'(i), 3'd3, 1'b1, 8'(i * 8), 8'hFF);
            check("t3_wfull_fill", 64'(wfull), 64'((i + 1) >= 6));
        end
        check("t3_level_full", 64'(level), 64'd8);
        cmd_ready = 1'b1;
        push(8'h70, 64'hBAD0, 3'd3, 1'b0, 8'h00, 8'h00);
        check("t3_werr_full", 64'(werr), 64'd1);
        check("t3_level_pop_only", 64'(level), 64'd7);
        check("t3_wfull_7", 64'(wfull), 64'd1);
        for (int l = 6; l >= 0; l--) begin
            tick();
            check("t3_level_drain", 64'(level), 64'(l));
            check("t3_wfull_drain", 64'(wfull), 64'(l >= 6));
        end
        cmd_ready = 1'b0;

        // 4: steady state at level 4 with pointer wrap
        for (int i = 0; i < 4; i++) begin
            push(8'(8'h24 + 8 * i), 64'h4000 + 64'(i), 3'd2, 1'b1, 8'(8'h20 + 8 * i), 8'hF0);
        end
        check("t4_level_start", 64'(level), 64'd4);
        cmd_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push(8'(8'h02 + 8 * i), 64'h5000 + 64'(i), 3'd1, 1'b1, 8'(8 * i), 8'h0C);
            check("t4_level_steady", 64'(level), 64'd4);
        end
        drain(20);

        // 5: flush with a concurrent strobe
        for (int i = 0; i < 6; i++) begin
            push(8'h05, 64'h6000 + 64'(i), 3'd0, 1'b1, 8'h00, 8'h20);
        end
        check("t5_wfull_pre", 64'(wfull), 64'd1);
        flush   = 1'b1;
        addr    = 8'h08;
        wdata   = 64'h7777;
        wburst  = 3'd3;
        wstrobe = 1'b1;
        discard_expected();
        tick();
        flush   = 1'b0;
        wstrobe = 1'b0;
        check("t5_level", 64'(level), 64'd0);
        check("t5_valid", 64'(cmd_valid), 64'd0);
        check("t5_wfull", 64'(wfull), 64'd0);
        check("t5_werr", 64'(werr), 64'd0);
        tick();
        check("t5_werr_late", 64'(werr), 64'd0);

        // 6: asynchronous reset mid-cycle, then one clean beat
        for (int i = 0; i < 3; i++) begin
            push(8'h48, 64'h8000 + 64'(i), 3'd3, 1'b1, 8'h48, 8'hFF);
        end
        check("t6_level_pre", 64'(level), 64'd3);
        @(posedge clk);
        #3;
        rst = 1'b1;
        discard_expected();
        #1;
        check("t6_rst_level", 64'(level), 64'd0);
        check("t6_rst_valid", 64'(cmd_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        push(8'h38, 64'hCAFE_F00D_0000_0001, 3'd3, 1'b1, 8'h38, 8'hFF);
        cmd_ready = 1'b1;
        tick();
        check("t6_level_after", 64'(level), 64'd0);
        tick();
        tick();
        cmd_ready = 1'b0;

        check("total_pops", 64'(pops), 64'(exp_total));
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
